// File: rtl/dmem_pkg.sv
// Shared types, funct3 encodings and access-legality helpers for the data-memory controller.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT_R = 2'd2,
        ST_DONE   = 2'd3
    } dmem_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Size is carried in f3[1:0] for both signed and unsigned variants.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic r;
        case (f3[1:0])
            2'b01:   r = a[0];
            2'b10:   r = (a != 2'b00);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic illegal_f3(input logic is_store, input logic [2:0] f3);
        logic r;
        if (is_store) begin
            r = (f3 > F3_W);
        end else begin
            r = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        end
        return r;
    endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword of a bus word and sign- or zero-extends it.
module load_align
    import dmem_pkg::*;
(
    input  logic [2:0]  i_f3,
    input  logic [1:0]  i_a,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_data
);

    logic [31:0] w_shift;

    assign w_shift = i_rdata >> {i_a, 3'b000};

    // Extension by access type
    always_comb begin
        case (i_f3)
            F3_B:    o_data = {{24{w_shift[7]}}, w_shift[7:0]};
            F3_H:    o_data = {{16{w_shift[15]}}, w_shift[15:0]};
            F3_W:    o_data = i_rdata;
            F3_BU:   o_data = {24'd0, w_shift[7:0]};
            F3_HU:   o_data = {16'd0, w_shift[15:0]};
            default: o_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Load/store controller: one access at a time over a req/gnt/rvalid word bus,
// with load alignment, stall generation, and misaligned/illegal/timeout errors.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        d_r_en,
    input  logic        d_w_en,
    input  logic [31:0] d_add,
    input  logic [2:0]  f3,
    input  logic [31:0] st_data,
    input  logic [4:0]  rd_in,
    output logic        stall,
    output logic        resp_valid,
    output logic        resp_we,
    output logic [4:0]  resp_rd,
    output logic [31:0] resp_data,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    dmem_state_t      r_state;
    dmem_state_t      w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_load;
    logic             r_err;
    logic [2:0]       r_f3;
    logic [1:0]       r_lane;
    logic [4:0]       r_rd;
    logic [31:0]      r_data;
    logic             r_mem_req;
    logic             r_mem_we;
    logic [3:0]       r_mem_be;
    logic [29:0]      r_mem_addr;
    logic [31:0]      r_mem_wdata;

    logic             w_req;
    logic             w_bad;
    logic             w_tmo;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic [31:0]      w_load_data;

    assign w_req = d_r_en | d_w_en;
    assign w_bad = illegal_f3(d_w_en, f3) | misaligned(f3, d_add[1:0]);
    assign w_tmo = (r_cnt == CNT_LAST);

    load_align u_load_align (
        .i_f3    (r_f3),
        .i_a     (r_lane),
        .i_rdata (mem_rdata),
        .o_data  (w_load_data)
    );

    // Byte enables and lane-replicated write data for the incoming request
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = st_data;
        if (d_w_en) begin
            case (f3[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << d_add[1:0];
                    w_wdata = {4{st_data[7:0]}};
                end
                2'b01: begin
                    w_be    = 4'b0011 << d_add[1:0];
                    w_wdata = {2{st_data[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = st_data;
                end
            endcase
        end else begin
            w_be    = 4'b1111;
            w_wdata = st_data;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a handshake on the last counted cycle still wins over the timeout
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_next = w_bad ? ST_DONE : ST_ISSUE;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (mem_gnt) begin
                    w_next = r_is_load ? ST_WAIT_R : ST_DONE;
                end else if (w_tmo) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_ISSUE;
                end
            end
            ST_WAIT_R: begin
                if (mem_rvalid || w_tmo) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_WAIT_R;
                end
            end
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        stall      = 1'b0;
        resp_valid = 1'b0;
        resp_we    = 1'b0;
        err        = 1'b0;
        case (r_state)
            ST_IDLE:   stall = w_req;
            ST_ISSUE:  stall = 1'b1;
            ST_WAIT_R: stall = 1'b1;
            ST_DONE: begin
                resp_valid = 1'b1;
                resp_we    = r_is_load & ~r_err;
                err        = r_err;
            end
            default:   stall = 1'b0;
        endcase
    end

    // Wait counter, restarted on every state change
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_next != r_state) begin
            r_cnt <= '0;
        end else if (r_state == ST_ISSUE || r_state == ST_WAIT_R) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Request capture, bus registers, load data and error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_load   <= 1'b0;
            r_err       <= 1'b0;
            r_f3        <= 3'd0;
            r_lane      <= 2'd0;
            r_rd        <= 5'd0;
            r_data      <= 32'd0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 4'd0;
            r_mem_addr  <= 30'd0;
            r_mem_wdata <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_is_load   <= ~d_w_en;
                        r_err       <= w_bad;
                        r_f3        <= f3;
                        r_lane      <= d_add[1:0];
                        r_rd        <= rd_in;
                        r_data      <= 32'd0;
                        r_mem_we    <= d_w_en;
                        r_mem_be    <= w_be;
                        r_mem_addr  <= d_add[31:2];
                        r_mem_wdata <= w_wdata;
                    end
                end
                ST_ISSUE: begin
                    if (!mem_gnt && w_tmo) begin
                        r_err <= 1'b1;
                    end
                end
                ST_WAIT_R: begin
                    if (mem_rvalid) begin
                        r_data <= w_load_data;
                    end else if (w_tmo) begin
                        r_err <= 1'b1;
                    end
                end
                default: begin
                    r_err <= r_err;
                end
            endcase
            r_mem_req <= (w_next == ST_ISSUE);
        end
    end

    assign resp_rd   = r_rd;
    assign resp_data = r_data;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_be    = r_mem_be;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory controller on the memory side of the RV32 execute stage. It accepts load/store requests (`d_r_en`, `d_w_en`, `d_add`, `f3`, store data, destination register) and issues aligned word accesses with byte enables over a request/grant/rvalid SRAM-style bus. It aligns and sign- or zero-extends load data, and returns a one-cycle writeback response. It stalls the pipeline for the whole access and flags misaligned accesses, illegal accesses and bus timeouts.

## Interface
- `TIMEOUT_CYC`, default 16: maximum cycles spent waiting for `mem_gnt` or `mem_rvalid` before aborting with `err`.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `d_r_en` in 1: load request.
- `d_w_en` in 1: store request. Wins if `d_r_en` is also high.
- `d_add` in 32: byte address.
- `f3` in 3: access type (funct3).
- `st_data` in 32: store data, right-justified.
- `rd_in` in 5: load destination register.
- `stall` out 1: upstream must hold all request inputs while high.
- `resp_valid` out 1: one-cycle completion pulse, for loads and stores.
- `resp_we` out 1: register-file write enable. Equals `resp_valid` for successful loads.
- `resp_rd` out 5: latched `rd_in`.
- `resp_data` out 32: extended load data; 0 for stores and errors.
- `err` out 1: one-cycle pulse, asserted coincident with `resp_valid`, on misaligned, illegal or timeout.
- `mem_req` out 1: bus request.
- `mem_we` out 1: bus write.
- `mem_be` out 4: byte enables.
- `mem_addr` out 30: word address, `d_add[31:2]`.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_gnt` in 1: request accepted this cycle.
- `mem_rvalid` in 1: read data valid.
- `mem_rdata` in 32: read data.

## Operation
- States: IDLE, ISSUE, WAIT_R, DONE.
- **IDLE, request present**:
  - Latch address, `f3`, store data, `rd_in` and the operation type.
  - Illegal cases: load `f3` ∈ {011, 110, 111}; store `f3` > 010; halfword with `d_add[0]`=1; word with `d_add[1:0]`≠0. Any of these goes to DONE with the error flag set and no bus activity.
  - Otherwise go to ISSUE.
- **ISSUE**:
  - `mem_req`=1 with latched `mem_addr`, `mem_we`, `mem_be`, `mem_wdata`.
  - On `mem_gnt`, a store goes to DONE (posted write) and a load goes to WAIT_R.
- **WAIT_R**: `mem_req`=0. On `mem_rvalid`, capture the aligned load data and go to DONE.
- **DONE**:
  - `resp_valid`=1 and `stall`=0, then return to IDLE.
  - `resp_we`=1 only for a successful load.
- **Byte enables**:
  - SB: `be`=0001<<a[1:0], `wdata`={4{st_data[7:0]}}.
  - SH: `be`=0011<<a[1:0], `wdata`={2{st_data[15:0]}}.
  - SW: `be`=1111.
  - Loads drive `be`=1111.
- **Load extraction**:
  - The byte/halfword is selected by a[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- **Timeout**:
  - The counter clears on entry to ISSUE and on entry to WAIT_R, and increments every cycle in those states.
  - Reaching `TIMEOUT_CYC`-1 without the awaited handshake goes to DONE with `err`=1 and `resp_we`=0.
- **Reset mid-operation**: forces IDLE next edge and drops `mem_req`. A `mem_rvalid` arriving in IDLE or DONE is ignored.

## Timing
- `stall` = (IDLE & (`d_r_en`|`d_w_en`)) | ISSUE | WAIT_R. The IDLE term is combinational.
- Reset values:
  - State IDLE.
  - `stall`, `resp_valid`, `resp_we`, `err`, `mem_req`, `mem_we` all 0.
  - `resp_rd`, `resp_data`, `mem_be`, `mem_addr`, `mem_wdata` all 0.
- Minimum load latency (gnt in ISSUE, rvalid the next cycle): 4 cycles. Accept in cycle 0, ISSUE in 1, WAIT_R in 2, DONE in 3.
- `mem_rvalid` is never earlier than the cycle after `mem_gnt`.
- Minimum store latency: 3 cycles (accept, ISSUE+gnt, DONE).
- Error without bus access: 2 cycles (accept, DONE).
- Bus outputs are registered and stable for the whole ISSUE residency.
- Upstream advances on the edge that ends DONE; the next request is evaluated in the following IDLE cycle. Maximum throughput is therefore one access per 3 cycles.

## Structure
- `dmem_pkg` holds:
  - state enum `dmem_state_t`;
  - funct3 constants `F3_B`=000, `F3_H`=001, `F3_W`=010, `F3_BU`=100, `F3_HU`=101;
  - a `misaligned(f3, a[1:0])` function.
- Sub-module `load_align` (combinational): `f3`, `a[1:0]`, `rdata` → extended 32-bit word. It is instantiated once and tested standalone.

## Test plan
- **SW**: `d_w_en`=1, `d_add`=0x100, `f3`=010, `st_data`=0xDEADBEEF, gnt on first ISSUE cycle → `mem_addr`=0x40, `be`=1111, `wdata`=0xDEADBEEF; `resp_valid`=1 in cycle 2 with `resp_we`=0.
- **LB sign extension**: `d_add`=0x103, `f3`=000, `rdata`=0x80112233 → `resp_data`=0xFFFFFF80, `resp_rd` = latched rd, `resp_we`=1. Repeat with `f3`=100 → 0x00000080.
- **SH lane select**: `d_add`=0x202, `f3`=001, `st_data`=0x0000ABCD → `be`=1100, `wdata`=0xABCDABCD.
- **Misaligned**: LW at 0x101 → no `mem_req` ever, `err`=1 and `resp_valid`=1 in cycle 1, `resp_we`=0. Also illegal load `f3`=011 → same response.
- **Timeout**: `TIMEOUT_CYC`=16, gnt given, rvalid never → DONE with `err`=1 after 16 WAIT_R cycles; `stall` low in that DONE cycle.
- **Reset mid-access**: `rst` in WAIT_R, then `mem_rvalid` one cycle later → no `resp_valid`, state IDLE, all outputs at reset values.
